// File: rtl/core_if.sv
// ---------------------------------------------------------------------------
// core_if: instruction fetch stage of the i2d core pipeline.
//
// Issues sequential word fetches on the instruction bus. At most one request
// is outstanding. Returned words go into a small prefetch FIFO, and the head
// entry is shown to decode together with its PC. A fetch bus fault is queued
// in order like a normal word. It is reported to core control when it reaches
// the head, and it stays there until a redirect clears it.
//
// Parameters
//   RESET_PC    first fetch address after reset
//   FIFO_DEPTH  prefetch buffer entries (2 or 4)
//
// Ports
//   clk, rst     core clock, synchronous active-high reset
//   set_pc       redirect request from core control (highest priority)
//   new_pc       redirect target, word aligned
//   if_halt      decode stall: the head entry is not consumed
//   ibus_req     fetch request (registered)
//   ibus_addr    fetch address (registered)
//   ibus_ack     completion of the outstanding request
//   ibus_rdata   fetched word, valid with ibus_ack
//   ibus_err     bus fault, valid with ibus_ack
//   id_valid     head entry is a valid instruction
//   id_inst      head instruction word (0 when empty)
//   if_pc        PC of the head entry / faulting address (0 when empty)
//   if_err       head entry is a fetch fault
//
// Bus handshake: ibus_req is a request-valid. While ibus_req is high, ibus_req
// and ibus_addr stay steady. The request completes in the cycle that ibus_ack
// is sampled high at a rising clk edge. ibus_rdata and ibus_err are looked at
// only in that cycle. ibus_ack is ignored while ibus_req is low. The FIFO
// towards decode has no ready signal. The head entry is consumed at an edge
// where id_valid is high and if_halt is low.
// ---------------------------------------------------------------------------
module core_if #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_pc,
    input  logic [31:0] new_pc,
    input  logic        if_halt,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_ack,
    input  logic [31:0] ibus_rdata,
    input  logic        ibus_err,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] if_pc,
    output logic        if_err
);

    typedef logic [31:0] addr_t;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2,
        S_FAULT   = 2'd3
    } state_t;

    // Only depths of 2 and 4 are legal. Both are powers of two, so the
    // pointers wrap naturally.
    localparam int PTR_W = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    // FSM state; kept as a plain named register so it is easy to observe.
    state_t state, state_n;

    addr_t  fetch_pc, fetch_pc_n;
    logic   req_q, req_n;
    addr_t  addr_q, addr_n;

    // Prefetch FIFO storage: {inst, pc, err} per entry.
    logic [31:0]      inst_mem [FIFO_DEPTH];
    addr_t            pc_mem   [FIFO_DEPTH];
    logic             err_mem  [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic             fifo_empty;
    logic             head_err;
    logic             pop;
    logic             push;
    logic             clear;
    logic [CNT_W-1:0] count_after;

    assign fifo_empty = (count == '0);
    assign head_err   = err_mem[rd_ptr];

    // An error head is never consumed. Only a redirect removes it.
    assign pop = !fifo_empty && !if_halt && !head_err && !set_pc;

    // Occupancy after this cycle's ack push and head pop. It decides whether
    // the next request can go back-to-back.
    assign count_after = count + CNT_W'(1) - {{(CNT_W-1){1'b0}}, pop};

    // -----------------------------------------------------------------------
    // Next-state / bus request logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        req_n      = req_q;
        addr_n     = addr_q;
        push       = 1'b0;
        clear      = 1'b0;

        if (set_pc) begin
            clear = 1'b1;
            if (req_q && !ibus_ack) begin
                // The old request is still in flight. Keep presenting it and
                // drop its data when it returns.
                fetch_pc_n = new_pc;
                state_n    = S_DISCARD;
            end else begin
                // The bus is free this cycle (any ack data is dropped), so
                // the target is requested right away.
                req_n      = 1'b1;
                addr_n     = new_pc;
                fetch_pc_n = new_pc + 32'd4;
                state_n    = S_WAIT;
            end
        end else begin
            case (state)
                S_RUN: begin
                    // No request is outstanding in RUN.
                    if (count < DEPTH_C) begin
                        req_n      = 1'b1;
                        addr_n     = fetch_pc;
                        fetch_pc_n = fetch_pc + 32'd4;
                        state_n    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ibus_ack) begin
                        push = 1'b1;
                        if (ibus_err) begin
                            req_n   = 1'b0;
                            state_n = S_FAULT;
                        end else if (count_after < DEPTH_C) begin
                            addr_n     = fetch_pc;
                            fetch_pc_n = fetch_pc + 32'd4;
                        end else begin
                            req_n   = 1'b0;
                            state_n = S_RUN;
                        end
                    end
                end
                S_DISCARD: begin
                    if (ibus_ack) begin
                        req_n   = 1'b0;
                        state_n = S_RUN;
                    end
                end
                S_FAULT: begin
                    // Held until a redirect. Older entries still drain.
                end
                default: begin
                    state_n = S_RUN;
                    req_n   = 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State, bus and FIFO control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_RUN;
            fetch_pc <= RESET_PC;
            req_q    <= 1'b0;
            addr_q   <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            req_q    <= req_n;
            addr_q   <= addr_n;
            if (clear) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (push && !pop) begin
                    count <= count + CNT_W'(1);
                end else if (pop && !push) begin
                    count <= count - CNT_W'(1);
                end
            end
        end
    end

    // FIFO payload needs no reset. Empty entries are hidden by the head
    // output gating below.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            inst_mem[wr_ptr] <= ibus_rdata;
            pc_mem[wr_ptr]   <= addr_q;
            err_mem[wr_ptr]  <= ibus_err;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign ibus_req  = req_q;
    assign ibus_addr = addr_q;

    assign id_valid = !fifo_empty && !head_err;
    assign if_err   = !fifo_empty && head_err;
    assign id_inst  = fifo_empty ? 32'd0 : inst_mem[rd_ptr];
    assign if_pc    = fifo_empty ? 32'd0 : pc_mem[rd_ptr];

endmodule

// File: tb/tb_core_if.sv
module tb_core_if;

  logic        clk;
  logic        rst;
  logic        set_pc;
  logic [31:0] new_pc;
  logic        if_halt;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ack;
  logic [31:0] ibus_rdata;
  logic        ibus_err;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] if_pc;
  logic        if_err;

  int n_cmp;
  int n_bad;
  int n_acks;

  // Bus agent controls
  bit          auto_ack;
  bit          force_ack;
  logic [31:0] err_addr;

  core_if #(
    .RESET_PC   (32'h0000_0100),
    .FIFO_DEPTH (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .set_pc     (set_pc),
    .new_pc     (new_pc),
    .if_halt    (if_halt),
    .ibus_req   (ibus_req),
    .ibus_addr  (ibus_addr),
    .ibus_ack   (ibus_ack),
    .ibus_rdata (ibus_rdata),
    .ibus_err   (ibus_err),
    .id_valid   (id_valid),
    .id_inst    (id_inst),
    .if_pc      (if_pc),
    .if_err     (if_err)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents that the bus agent returns for an address
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive the bus response for the current request, then sample
  // #1 after the rising edge.
  task automatic cycle();
    ibus_ack   = auto_ack ? ibus_req : (force_ack & ibus_req);
    ibus_rdata = inst_of(ibus_addr);
    ibus_err   = ibus_ack && (ibus_addr == err_addr);
    if (ibus_ack) n_acks++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; n_acks = 0;
    rst = 1'b1; set_pc = 1'b0; new_pc = '0; if_halt = 1'b0;
    ibus_ack = 1'b0; ibus_rdata = '0; ibus_err = 1'b0;
    auto_ack = 1'b0; force_ack = 1'b0; err_addr = 32'hFFFF_FFF0;

    // reset
    cycle(); cycle();
    chk("rst_req",   {31'd0, ibus_req}, 32'd0);
    chk("rst_addr",  ibus_addr, 32'd0);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_inst",  id_inst, 32'd0);
    chk("rst_pc",    if_pc, 32'd0);
    chk("rst_err",   {31'd0, if_err}, 32'd0);

    // sequential fetch, zero-wait bus
    rst = 1'b0; auto_ack = 1'b1;
    cycle();
    chk("seq_req0",   {31'd0, ibus_req}, 32'd1);
    chk("seq_addr0",  ibus_addr, 32'h100);
    chk("seq_valid0", {31'd0, id_valid}, 32'd0);
    cycle();
    chk("seq_addr1",  ibus_addr, 32'h104);
    chk("seq_valid1", {31'd0, id_valid}, 32'd1);
    chk("seq_pc1",    if_pc, 32'h100);
    chk("seq_inst1",  id_inst, inst_of(32'h100));
    cycle();
    chk("seq_addr2",  ibus_addr, 32'h108);
    chk("seq_pc2",    if_pc, 32'h104);
    chk("seq_valid2", {31'd0, id_valid}, 32'd1);
    cycle();
    chk("seq_addr3",  ibus_addr, 32'h10C);
    chk("seq_pc3",    if_pc, 32'h108);

    // halt: FIFO fills to 2 (0x108, 0x10C), bus goes idle, head holds
    if_halt = 1'b1; n_acks = 0;
    repeat (5) cycle();
    chk("halt_acks",  n_acks, 32'd1);
    chk("halt_req",   {31'd0, ibus_req}, 32'd0);
    chk("halt_pc",    if_pc, 32'h108);
    chk("halt_inst",  id_inst, inst_of(32'h108));
    chk("halt_valid", {31'd0, id_valid}, 32'd1);
    if_halt = 1'b0;
    cycle();
    chk("drain_pc1",  if_pc, 32'h10C);
    chk("drain_req1", {31'd0, ibus_req}, 32'd0);
    cycle();
    chk("drain_valid2", {31'd0, id_valid}, 32'd0);
    chk("drain_req2",   {31'd0, ibus_req}, 32'd1);
    chk("drain_addr2",  ibus_addr, 32'h110);

    // redirect while the 0x110 request is outstanding: discard it
    auto_ack = 1'b0; force_ack = 1'b0;
    set_pc = 1'b1; new_pc = 32'h2000;
    cycle();
    set_pc = 1'b0;
    chk("disc_req",   {31'd0, ibus_req}, 32'd1);
    chk("disc_addr",  ibus_addr, 32'h110);
    chk("disc_valid", {31'd0, id_valid}, 32'd0);
    cycle(); cycle();
    chk("disc_addr_hold", ibus_addr, 32'h110);
    force_ack = 1'b1;
    cycle();
    force_ack = 1'b0;
    chk("disc_done_req",   {31'd0, ibus_req}, 32'd0);
    chk("disc_done_valid", {31'd0, id_valid}, 32'd0);
    cycle();
    chk("redir_req",   {31'd0, ibus_req}, 32'd1);
    chk("redir_addr",  ibus_addr, 32'h2000);
    chk("redir_valid", {31'd0, id_valid}, 32'd0);
    auto_ack = 1'b1;
    cycle();
    chk("redir_pc",    if_pc, 32'h2000);
    chk("redir_inst",  id_inst, inst_of(32'h2000));
    chk("redir_addr1", ibus_addr, 32'h2004);

    // redirect in the same cycle as an ack: data dropped, no discard
    set_pc = 1'b1; new_pc = 32'h104;
    cycle();
    set_pc = 1'b0;
    chk("same_req",   {31'd0, ibus_req}, 32'd1);
    chk("same_addr",  ibus_addr, 32'h104);
    chk("same_valid", {31'd0, id_valid}, 32'd0);

    // bus fault on 0x10C: older words first, then a held fault
    err_addr = 32'h10C;
    cycle();
    chk("flt_pc0",  if_pc, 32'h104);
    cycle();
    chk("flt_pc1",  if_pc, 32'h108);
    cycle();
    chk("flt_err",   {31'd0, if_err}, 32'd1);
    chk("flt_pc",    if_pc, 32'h10C);
    chk("flt_valid", {31'd0, id_valid}, 32'd0);
    chk("flt_req",   {31'd0, ibus_req}, 32'd0);
    repeat (3) cycle();
    chk("flt_hold_err", {31'd0, if_err}, 32'd1);
    chk("flt_hold_pc",  if_pc, 32'h10C);
    chk("flt_hold_req", {31'd0, ibus_req}, 32'd0);
    set_pc = 1'b1; new_pc = 32'h40;
    cycle();
    set_pc = 1'b0;
    chk("flt_clr_err",  {31'd0, if_err}, 32'd0);
    chk("flt_clr_req",  {31'd0, ibus_req}, 32'd1);
    chk("flt_clr_addr", ibus_addr, 32'h40);
    cycle();
    chk("flt_res_pc",    if_pc, 32'h40);
    chk("flt_res_valid", {31'd0, id_valid}, 32'd1);
    chk("flt_res_addr",  ibus_addr, 32'h44);

    // address wrap
    set_pc = 1'b1; new_pc = 32'hFFFF_FFFC;
    cycle();
    set_pc = 1'b0;
    chk("wrap_addr0", ibus_addr, 32'hFFFF_FFFC);
    cycle();
    chk("wrap_addr1", ibus_addr, 32'h0000_0000);
    chk("wrap_pc",    if_pc, 32'hFFFF_FFFC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
